// File: rtl/bypass_write_combiner.sv
// rtl/bypass_write_combiner.sv - gathers CPU word stores into a 32-byte line and flushes it as one DDR2 write
// Stores to one line merge into a byte-masked buffer; a flush is 1 command push then 2 data beats.
module bypass_write_combiner #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_valid,
  input  logic [31:0]    wr_addr,
  input  logic [31:0]    wr_din,
  input  logic [3:0]     wr_we,
  input  logic           flush,
  output logic           stall,
  output logic           empty,
  input  logic           af_full,
  input  logic           wdf_full,
  output logic [2:0]     af_cmd_din,
  output logic [30:0]    af_addr_din,
  output logic           af_wr_en,
  output logic [127:0]   wdf_din,
  output logic [15:0]    wdf_mask_din,
  output logic           wdf_wr_en
);

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    FILL  = 3'd1,
    AF    = 3'd2,
    WD0   = 3'd3,
    WD1   = 3'd4
  } state_t;

  // Idle timeout fires when the count before the edge is TIMEOUT-1, so the
  // FSM leaves FILL exactly TIMEOUT edges after the last accepted store.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [255:0]       line_q, line_d;
  logic [31:0]        valid_q, valid_d;
  logic [26:0]        tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [255:0]       line_m;
  logic [31:0]        valid_m;
  logic               store_req;
  logic               same_tag;
  logic               accept;
  logic               timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      line_q  <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte merge of the presented store into the current line image.
  always_comb begin
    line_m  = line_q;
    valid_m = valid_q;
    for (int j = 0; j < 4; j++) begin
      if (wr_we[j]) begin
        line_m[{wr_addr[4:2], 2'(j), 3'b000} +: 8] = wr_din[8*j +: 8];
        valid_m[{wr_addr[4:2], 2'(j)}]            = 1'b1;
      end
    end
  end

  always_comb begin
    store_req   = wr_valid && (wr_we != 4'b0000);
    same_tag    = (wr_addr[31:5] == tag_q);
    timeout_hit = (cnt_q == TO_LAST);
    stall       = store_req &&
                  ((state_q == AF) || (state_q == WD0) || (state_q == WD1) ||
                   ((state_q == FILL) && !same_tag));
    accept      = store_req && !stall;
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          tag_d   = wr_addr[31:5];
          line_d  = line_m;
          valid_d = valid_m;
          cnt_d   = '0;
          state_d = FILL;
        end
      end

      FILL: begin
        if (accept) begin
          line_d  = line_m;
          valid_d = valid_m;
          cnt_d   = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A mismatching store only triggers the flush; it is taken later from EMPTY.
        if ((accept && (&valid_m)) || flush || timeout_hit || (store_req && !same_tag)) begin
          state_d = AF;
        end
      end

      AF: begin
        af_wr_en = !af_full;
        if (!af_full) begin
          state_d = WD0;
        end
      end

      WD0: begin
        wdf_wr_en = !wdf_full;
        if (!wdf_full) begin
          state_d = WD1;
        end
      end

      WD1: begin
        wdf_wr_en = !wdf_full;
        if (!wdf_full) begin
          valid_d = '0;
          cnt_d   = '0;
          state_d = EMPTY;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign empty        = (state_q == EMPTY);
  assign af_cmd_din   = 3'b000;
  assign af_addr_din  = {6'b0, tag_q[22:0], 2'b00};
  assign wdf_din      = (state_q == WD1) ? line_q[255:128] : line_q[127:0];
  assign wdf_mask_din = (state_q == WD1) ? ~valid_q[31:16] : ~valid_q[15:0];

endmodule

// File: tb/tb_bypass_write_combiner.sv
// tb/tb_bypass_write_combiner.sv - directed self-checking bench for bypass_write_combiner
// Linear directed steps; a posedge monitor records FIFO pushes for later checks.
module tb_bypass_write_combiner;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic           clk;
  logic           rst_n;
  logic           wr_valid;
  logic [31:0]    wr_addr;
  logic [31:0]    wr_din;
  logic [3:0]     wr_we;
  logic           flush;
  logic           stall;
  logic           empty;
  logic           af_full;
  logic           wdf_full;
  logic [2:0]     af_cmd_din;
  logic [30:0]    af_addr_din;
  logic           af_wr_en;
  logic [127:0]   wdf_din;
  logic [15:0]    wdf_mask_din;
  logic           wdf_wr_en;

  int n_assert;
  int n_fail;
  int af_pushes;
  int wdf_pushes;
  int full_viol;
  int stalls_seen;
  logic [30:0]  cap_addr;
  logic [127:0] cap_din  [0:1];
  logic [15:0]  cap_mask [0:1];

  bypass_write_combiner #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_din       (wr_din),
    .wr_we        (wr_we),
    .flush        (flush),
    .stall        (stall),
    .empty        (empty),
    .af_full      (af_full),
    .wdf_full     (wdf_full),
    .af_cmd_din   (af_cmd_din),
    .af_addr_din  (af_addr_din),
    .af_wr_en     (af_wr_en),
    .wdf_din      (wdf_din),
    .wdf_mask_din (wdf_mask_din),
    .wdf_wr_en    (wdf_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (af_wr_en) begin
        af_pushes = af_pushes + 1;
        cap_addr  = af_addr_din;
        if (af_full) full_viol = full_viol + 1;
      end
      if (wdf_wr_en) begin
        cap_din[wdf_pushes & 1]  = wdf_din;
        cap_mask[wdf_pushes & 1] = wdf_mask_din;
        wdf_pushes = wdf_pushes + 1;
        if (wdf_full) full_viol = full_viol + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    af_pushes   = 0;
    wdf_pushes  = 0;
    full_viol   = 0;
    stalls_seen = 0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_din   = '0;
    wr_we    = '0;
    flush    = 1'b0;
    af_full  = 1'b0;
    wdf_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_counts();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    int n;
    n        = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_din   = d;
    wr_we    = we;
    #1;
    while (stall && n < 50) begin
      stalls_seen++;
      tick();
      n++;
    end
    if (n >= 50) chk("store_timeout", stall, 1'b0);
    tick();
    wr_valid = 1'b0;
    wr_we    = 4'b0000;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!empty && n < 200) begin
      tick();
      n++;
    end
    chk("wait_empty", empty, 1'b1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clear_counts();
    do_reset();

    // Reset state
    chk("rst_empty", empty, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_af_wr_en", af_wr_en, 1'b0);
    chk("rst_wdf_wr_en", wdf_wr_en, 1'b0);
    chk("af_cmd", af_cmd_din, 3'b000);

    // Full sequential line of 8 words
    for (int k = 0; k < 8; k++) store(32'h0040_0020 + 32'(4 * k), 32'(k), 4'hF);
    chk("seq_no_stall", stalls_seen, 0);
    chk("seq_af_wr_en", af_wr_en, 1'b1);
    chk("seq_af_addr", af_addr_din, 31'h0008_0004);
    wait_empty();
    chk("seq_af_pushes", af_pushes, 1);
    chk("seq_wdf_pushes", wdf_pushes, 2);
    chk("seq_wd0_din", cap_din[0], 128'h00000003_00000002_00000001_00000000);
    chk("seq_wd0_mask", cap_mask[0], 16'h0000);
    chk("seq_wd1_din", cap_din[1], 128'h00000007_00000006_00000005_00000004);
    chk("seq_wd1_mask", cap_mask[1], 16'h0000);

    // Single partial store then idle timeout
    do_reset();
    store(32'h0040_0024, 32'hAABB_CCDD, 4'b0011);
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet", af_wr_en, 1'b0);
    tick();
    chk("to_af_wr_en", af_wr_en, 1'b1);
    wait_empty();
    chk("to_wd0_bytes45", cap_din[0][47:32], 16'hCCDD);
    chk("to_wd0_mask", cap_mask[0], 16'hFFCF);
    chk("to_wd1_mask", cap_mask[1], 16'hFFFF);
    chk("to_pushes", wdf_pushes, 2);

    // Tag mismatch stalls through the flush, then is accepted into a new line
    do_reset();
    store(32'h0040_0020, 32'h1111_1111, 4'hF);
    wr_valid = 1'b1;
    wr_addr  = 32'h0040_0040;
    wr_din   = 32'h2222_2222;
    wr_we    = 4'hF;
    #1;
    chk("mm_stall_fill", stall, 1'b1);
    tick();
    chk("mm_stall_af", {stall, af_wr_en}, 2'b11);
    tick();
    chk("mm_stall_wd0", {stall, wdf_wr_en}, 2'b11);
    tick();
    chk("mm_stall_wd1", {stall, wdf_wr_en}, 2'b11);
    tick();
    chk("mm_accept_now", {stall, empty}, 2'b01);
    tick();
    wr_valid = 1'b0;
    wr_we    = 4'b0000;
    chk("mm_new_fill", empty, 1'b0);
    // Flush one cycle after the store overrides the timeout
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_af_now", af_wr_en, 1'b1);
    chk("mm_new_tag", af_addr_din, 31'h0008_0008);
    wait_empty();
    chk("mm_wd0_din", cap_din[0][31:0], 32'h2222_2222);
    chk("mm_af_pushes", af_pushes, 2);

    // Flush while empty does nothing
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    chk("ef_empty", empty, 1'b1);
    chk("ef_no_push", af_pushes + wdf_pushes, 0);

    // Back-pressure from both FIFOs
    do_reset();
    store(32'h0040_0060, 32'h3333_3333, 4'hF);
    af_full = 1'b1;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_af_held", {af_wr_en, af_addr_din}, {1'b0, 31'h0008_000C});
      if (i < 9) tick();
    end
    af_full = 1'b0;
    #1;
    chk("bp_af_release", af_wr_en, 1'b1);
    tick();
    tick();
    wdf_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_wd1_held", {wdf_wr_en, wdf_mask_din, wdf_din}, {1'b0, 16'hFFFF, 128'h0});
      tick();
    end
    wdf_full = 1'b0;
    wait_empty();
    chk("bp_af_pushes", af_pushes, 1);
    chk("bp_wdf_pushes", wdf_pushes, 2);
    chk("bp_full_viol", full_viol, 0);
    chk("bp_wd0_din", cap_din[0][31:0], 32'h3333_3333);
    chk("bp_wd0_mask", cap_mask[0], 16'hFFF0);

    // Asynchronous reset during WD0 abandons the line
    do_reset();
    store(32'h0040_0080, 32'h4444_4444, 4'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("ar_in_wd0", wdf_wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en_drop", {af_wr_en, wdf_wr_en}, 2'b00);
    chk("ar_empty", empty, 1'b1);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("ar_no_wd1", wdf_pushes, 0);
    chk("ar_af_once", af_pushes, 1);
    chk("ar_still_empty", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
